// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit link controller: state encodings,
// default line patterns and arbiter grant indices.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        StDisabled = 2'b00,
        StTrain    = 2'b01,
        StIdle     = 2'b10,
        StRun      = 2'b11
    } link_state_e;

    localparam logic [31:0] TrainWordDefault = 32'hBCBCBCBC;
    localparam logic [31:0] IdleWordDefault  = 32'h7C7C7C7C;

    localparam int unsigned BurstW  = 4;
    localparam int unsigned GntData = 0;
    localparam int unsigned GntCtrl = 1;

endpackage

// File: rtl/tx_burst_arb.sv
// Two-requester arbiter for the TX slot: data wins by default, but a waiting
// control request is served after MaxBurst consecutive data grants.
module tx_burst_arb
    import phy_tx_pkg::*;
#(
    parameter int unsigned MaxBurst = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       data_req_i,
    input  logic       ctrl_req_i,
    output logic [1:0] grant_o
);

    logic [BurstW-1:0] burst_q, burst_d;

    always_comb begin
        grant_o = '0;
        if (en_i) begin
            if (data_req_i && (!ctrl_req_i || burst_q != BurstW'(MaxBurst))) begin
                grant_o[GntData] = 1'b1;
            end else if (ctrl_req_i) begin
                grant_o[GntCtrl] = 1'b1;
            end
        end
    end

    // Counter only measures how long a pending control word has been starved.
    always_comb begin
        burst_d = burst_q;
        if (!ctrl_req_i || grant_o[GntCtrl]) begin
            burst_d = '0;
        end else if (grant_o[GntData]) begin
            burst_d = burst_q + BurstW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// Link bring-up sequencer and TX slot owner in front of the two-lane PHY.
// Keeps the emitted word count even so both lanes stay balanced.
module phy_tx_link_ctrl
    import phy_tx_pkg::*;
#(
    parameter int unsigned TRAIN_WORDS = 8,
    parameter logic [31:0] TRAIN_WORD  = TrainWordDefault,
    parameter logic [31:0] IDLE_WORD   = IdleWordDefault,
    parameter int unsigned MAX_BURST   = 4
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        link_en,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_pop,
    input  logic        ctrl_req,
    input  logic [31:0] ctrl_word,
    output logic        ctrl_ack,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active_out,
    output logic [1:0]  state
);

    localparam int unsigned CntW = $clog2(TRAIN_WORDS + 1);

    link_state_e     state_q, state_d;
    logic [CntW-1:0] train_cnt_q, train_cnt_d;
    logic            parity_q, parity_d;
    logic [31:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            link_up;
    logic            arb_en;
    logic [1:0]      grant;

    assign link_up = (state_q == StIdle) || (state_q == StRun);
    assign arb_en  = link_en && link_up && !reset;

    tx_burst_arb #(
        .MaxBurst (MAX_BURST)
    ) u_arb (
        .clk_i      (clk_2f),
        .rst_i      (reset),
        .en_i       (arb_en),
        .data_req_i (!fifo_empty),
        .ctrl_req_i (ctrl_req),
        .grant_o    (grant)
    );

    assign fifo_pop   = grant[GntData];
    assign ctrl_ack   = grant[GntCtrl];
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign active_out = link_up;
    assign state      = state_q;

    // state_q describes what the output register currently presents.
    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        parity_d    = parity_q;
        data_d      = IDLE_WORD;
        valid_d     = 1'b0;
        unique case (state_q)
            StDisabled: begin
                data_d = '0;
                if (link_en) begin
                    state_d     = StTrain;
                    data_d      = TRAIN_WORD;
                    valid_d     = 1'b1;
                    train_cnt_d = CntW'(1);
                end
            end
            StTrain: begin
                if (!link_en && !train_cnt_q[0]) begin
                    state_d     = StDisabled;
                    data_d      = '0;
                    train_cnt_d = '0;
                end else if (link_en && train_cnt_q == CntW'(TRAIN_WORDS)) begin
                    state_d     = StIdle;
                    train_cnt_d = '0;
                    parity_d    = 1'b0;
                end else begin
                    // An odd count finishes its pair even when the link is dropping.
                    data_d      = TRAIN_WORD;
                    valid_d     = 1'b1;
                    train_cnt_d = train_cnt_q + CntW'(1);
                end
            end
            StIdle, StRun: begin
                if (grant[GntData]) begin
                    state_d  = StRun;
                    data_d   = fifo_data;
                    valid_d  = 1'b1;
                    parity_d = !parity_q;
                end else if (grant[GntCtrl]) begin
                    state_d  = StRun;
                    data_d   = ctrl_word;
                    valid_d  = 1'b1;
                    parity_d = !parity_q;
                end else if (parity_q) begin
                    state_d  = StIdle;
                    valid_d  = 1'b1;
                    parity_d = 1'b0;
                end else if (!link_en) begin
                    state_d = StDisabled;
                    data_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q     <= StDisabled;
            train_cnt_q <= '0;
            parity_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Scoreboard bench for phy_tx_link_ctrl: a FIFO/ctrl source model feeds the
// DUT while expected link-up words are queued and checked as they appear.
module tb_phy_tx_link_ctrl;

    localparam logic [31:0] TW = 32'hBCBCBCBC;
    localparam logic [31:0] IW = 32'h7C7C7C7C;
    localparam logic [31:0] CW = 32'h12345678;

    logic        clk_2f = 1'b0;
    logic        reset = 1'b1;
    logic        link_en = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        ctrl_req = 1'b0;
    logic [31:0] ctrl_word = '0;
    logic        fifo_pop, ctrl_ack, valid_out, active_out;
    logic [31:0] data_out;
    logic [1:0]  state;

    int          total = 0;
    int          bad = 0;
    int          sess = 0;
    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic        pop_seen = 1'b0;
    logic        ack_seen = 1'b0;

    phy_tx_link_ctrl #(
        .TRAIN_WORDS (8),
        .TRAIN_WORD  (TW),
        .IDLE_WORD   (IW),
        .MAX_BURST   (4)
    ) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .link_en    (link_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .ctrl_req   (ctrl_req),
        .ctrl_word  (ctrl_word),
        .ctrl_ack   (ctrl_ack),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active_out (active_out),
        .state      (state)
    );

    always #5 clk_2f = ~clk_2f;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1, "watchdog");
    end

    // Source model: consume FIFO head / drop ctrl_req after the edge that took them.
    always @(posedge clk_2f) begin
        #2;
        if (pop_seen && fq.size() != 0) void'(fq.pop_front());
        if (ack_seen) ctrl_req = 1'b0;
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fq[0];
        pop_seen   = 1'b0;
        ack_seen   = 1'b0;
    end

    // Scoreboard and invariants sampled away from the active edge.
    always @(negedge clk_2f) begin
        pop_seen = (fifo_pop === 1'b1);
        ack_seen = (ctrl_ack === 1'b1);
        total++;
        if ((fifo_pop & ctrl_ack) === 1'b1) begin
            bad++;
            $display("FAIL grant_exclusive: pop=%b ack=%b, required not both 1", fifo_pop, ctrl_ack);
        end
        if (valid_out === 1'b1 && active_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra: got %h, required no word", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_out !== mon_exp) begin
                    bad++;
                    $display("FAIL scoreboard_word: got %h, required %h", data_out, mon_exp);
                end
            end
        end
        if (reset) begin
            sess = 0;
        end else if (state === 2'b00) begin
            if (sess != 0) begin
                total++;
                if (sess % 2 != 0) begin
                    bad++;
                    $display("FAIL session_even: got %0d words, required even", sess);
                end
                sess = 0;
            end
        end else if (valid_out === 1'b1) begin
            sess++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        link_en = 1'b1;
        repeat (2) @(posedge clk_2f);
        @(negedge clk_2f);
        total++;
        if ({state, valid_out, active_out, fifo_pop, ctrl_ack, data_out} !== 38'h0) begin
            bad++;
            $display("FAIL reset_state: st=%b v=%b a=%b pop=%b ack=%b d=%h, required all 0",
                     state, valid_out, active_out, fifo_pop, ctrl_ack, data_out);
        end
        @(posedge clk_2f); #1;
        reset = 1'b0;
    endtask

    task automatic test_train();
        int k = 0;
        @(negedge clk_2f);
        while (state !== 2'b01 && k < 10) begin
            @(negedge clk_2f);
            k++;
        end
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL train_start: state=%b, required 01", state);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (state !== 2'b01 || valid_out !== 1'b1 || active_out !== 1'b0 || data_out !== TW) begin
                bad++;
                $display("FAIL train_word%0d: st=%b v=%b a=%b d=%h, required 01/1/0/%h",
                         i, state, valid_out, active_out, data_out, TW);
            end
            @(negedge clk_2f);
        end
        total++;
        if (state !== 2'b10 || active_out !== 1'b1 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL train_done: st=%b a=%b v=%b, required 10/1/0", state, active_out, valid_out);
        end
    endtask

    task automatic test_data();
        int pops = 0;
        @(posedge clk_2f); #1;
        fq.push_back(32'hAAAA0001); exp_q.push_back(32'hAAAA0001);
        fq.push_back(32'hBBBB0002); exp_q.push_back(32'hBBBB0002);
        fq.push_back(32'hCCCC0003); exp_q.push_back(32'hCCCC0003);
        exp_q.push_back(IW);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_2f);
            if (fifo_pop === 1'b1) pops++;
        end
        total++;
        if (pops != 3) begin
            bad++;
            $display("FAIL data_pops: got %0d, required 3", pops);
        end
        total++;
        if (exp_q.size() != 0 || valid_out !== 1'b0 || state !== 2'b10) begin
            bad++;
            $display("FAIL data_drain: left=%0d v=%b st=%b, required 0/0/10",
                     exp_q.size(), valid_out, state);
        end
    endtask

    task automatic test_burst();
        int pops = 0;
        int acks = 0;
        int pops_before = -1;
        @(posedge clk_2f); #1;
        for (int i = 0; i < 10; i++) fq.push_back(32'hD0000000 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hD0000000 + 32'(i));
        exp_q.push_back(CW);
        for (int i = 4; i < 10; i++) exp_q.push_back(32'hD0000000 + 32'(i));
        exp_q.push_back(IW);
        ctrl_word = CW;
        ctrl_req  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_2f);
            if (ctrl_ack === 1'b1) begin
                acks++;
                if (pops_before < 0) pops_before = pops;
            end
            if (fifo_pop === 1'b1) pops++;
        end
        total++;
        if (acks != 1 || pops_before != 4) begin
            bad++;
            $display("FAIL burst_ack: acks=%0d after %0d pops, required 1 after 4", acks, pops_before);
        end
        total++;
        if (pops != 10 || exp_q.size() != 0 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL burst_drain: pops=%0d left=%0d v=%b, required 10/0/0",
                     pops, exp_q.size(), valid_out);
        end
    endtask

    task automatic test_drop();
        int pops = 0;
        int k = 0;
        @(posedge clk_2f); #1;
        for (int i = 0; i < 5; i++) fq.push_back(32'hE0000000 + 32'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hE0000000 + 32'(i));
        exp_q.push_back(IW);
        while (pops < 3 && k < 20) begin
            @(negedge clk_2f);
            if (fifo_pop === 1'b1) pops++;
            k++;
        end
        @(posedge clk_2f); #1;
        link_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2f);
            total++;
            if (fifo_pop !== 1'b0 || ctrl_ack !== 1'b0) begin
                bad++;
                $display("FAIL drop_nogrant%0d: pop=%b ack=%b, required 0/0", i, fifo_pop, ctrl_ack);
            end
        end
        total++;
        if (state !== 2'b00 || valid_out !== 1'b0 || active_out !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drop_disabled: st=%b v=%b a=%b left=%0d, required 00/0/0/0",
                     state, valid_out, active_out, exp_q.size());
        end
        fq.delete();
    endtask

    task automatic test_reset_mid(input bit in_run);
        int k = 0;
        @(posedge clk_2f); #1;
        link_en = 1'b1;
        if (in_run) begin
            for (int i = 0; i < 6; i++) begin
                fq.push_back(32'hF0000000 + 32'(i));
                exp_q.push_back(32'hF0000000 + 32'(i));
            end
            repeat (3) @(negedge clk_2f);
        end else begin
            @(negedge clk_2f);
            while (state !== 2'b01 && k < 10) begin
                @(negedge clk_2f);
                k++;
            end
            repeat (2) @(negedge clk_2f);
        end
        @(posedge clk_2f); #1;
        reset = 1'b1;
        @(negedge clk_2f);
        total++;
        if (fifo_pop !== 1'b0 || ctrl_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant: pop=%b ack=%b, required 0/0", fifo_pop, ctrl_ack);
        end
        @(negedge clk_2f);
        total++;
        if ({state, valid_out, active_out, data_out} !== 36'h0) begin
            bad++;
            $display("FAIL reset_mid_%s: st=%b v=%b a=%b d=%h, required all 0",
                     in_run ? "run" : "train", state, valid_out, active_out, data_out);
        end
        fq.delete();
        exp_q.delete();
        @(posedge clk_2f); #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_train();
        test_data();
        test_burst();
        test_drop();
        test_reset_mid(1'b0);
        test_train();
        test_reset_mid(1'b1);
        test_train();
        @(posedge clk_2f); #1;
        link_en = 1'b0;
        repeat (3) @(negedge clk_2f);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phy_tx_link_ctrl.md
# phy_tx_link_ctrl

Link controller and source arbiter sitting in front of the two-lane PHY transmit path. It drives the TX datapath's `data_input`, `valid` and `active` inputs. It sequences link bring-up (DISABLED → TRAIN → IDLE/RUN) and shares the 32-bit transmit slot between a data FIFO and a control-word requester. It also keeps the word count even, so the lane-striping stage always leaves lane 0 and lane 1 balanced.

## Interface
Parameters:
- `TRAIN_WORDS`, 8: training words sent per bring-up; must be even and ≥2.
- `TRAIN_WORD`, 32'hBCBCBCBC: training pattern.
- `IDLE_WORD`, 32'h7C7C7C7C: pad/idle pattern.
- `MAX_BURST`, 4: maximum consecutive data words while a control request waits; range 1–15.

Ports:
- `clk_2f` in 1: the single clock, same domain as the TX recirculator.
- `reset` in 1: synchronous, active-high.
- `link_en` in 1: link enable.
- `fifo_empty` in 1: data FIFO empty.
- `fifo_data` in 32: FIFO head word, valid whenever `!fifo_empty`.
- `fifo_pop` out 1: head word is taken this cycle.
- `ctrl_req` in 1: control word pending.
- `ctrl_word` in 32: control word, stable while `ctrl_req` is high.
- `ctrl_ack` out 1: control word is taken this cycle.
- `data_out` out 32: to PHY `data_input`.
- `valid_out` out 1: to PHY `valid`.
- `active_out` out 1: to PHY `active`.
- `state` out 2: current state, for debug.

## Operation
- States: DISABLED=2'b00, TRAIN=2'b01, IDLE=2'b10, RUN=2'b11.
- **Reset values:** state DISABLED; all outputs 0; training counter, burst counter and parity bit 0.
- **DISABLED**
  - `valid_out`=0, `active_out`=0, no grants.
  - `link_en`=1 → TRAIN.
- **TRAIN**
  - Each cycle: `data_out`=TRAIN_WORD, `valid_out`=1, `active_out`=0. No grants.
  - After TRAIN_WORDS words → IDLE.
  - `link_en`=0 → DISABLED next cycle. Safe because the count is always even at a cycle boundary when TRAIN_WORDS is even and the count is aborted only after a pair.
  - Precisely: an abort is taken only when the training counter is even; otherwise one more TRAIN_WORD is sent first.
- **IDLE/RUN**
  - `active_out`=1.
  - Each cycle, at most one grant is issued (combinational `fifo_pop` or `ctrl_ack`).
  - Granted word → registered onto `data_out` with `valid_out`=1 next cycle; state RUN.
  - No grant and parity odd → emit IDLE_WORD with `valid_out`=1 (pad), parity becomes even, state IDLE.
  - No grant and parity even → `valid_out`=0, `data_out`=IDLE_WORD, state IDLE.
  - Parity toggles on every `valid_out`=1 word in IDLE/RUN.
- **Arbitration** (only while `link_en`=1):
  - Only ctrl pending → grant ctrl.
  - Only data pending → grant data.
  - Both pending → grant data unless burst count = MAX_BURST; then grant ctrl.
  - Burst count increments on each data grant while `ctrl_req`=1. It clears on a ctrl grant or on any cycle with `ctrl_req`=0.
- **`link_en`=0 in IDLE/RUN**
  - Grants stop the same cycle.
  - If parity is odd, one pad is emitted, then DISABLED; otherwise DISABLED next cycle.
  - In-flight registered word is still presented.
- `fifo_pop` and `ctrl_ack` are never both 1. Neither is asserted outside IDLE/RUN or during reset.

## Timing
- Grant → `data_out`/`valid_out`: 1 cycle.
- `fifo_pop`/`ctrl_ack` are combinational from registered state and the request inputs, with no combinational path to `data_out`.
- DISABLED → first TRAIN word on `valid_out`: 1 cycle after `link_en` is sampled high. Training lasts exactly TRAIN_WORDS cycles.
- Back-to-back grants sustain 1 word/cycle.
- Reset mid-operation: every register returns to its reset value on the next edge. Any partially sent pair is abandoned; the downstream PHY is reset by the same `reset`.

## Structure
- Shared package `phy_tx_pkg`: state encodings, default TRAIN_WORD and IDLE_WORD constants.
- Sub-module `tx_burst_arb`: the two-requester arbiter with burst counter. Inputs: requests, MAX_BURST, enable. Outputs: one-hot grant.
- Top level holds the FSM, training counter, parity bit and output register.

## Test plan
- Reset with `link_en`=1 held, release reset → `state` goes 01; exactly 8 cycles of `data_out`=BCBCBCBC, `valid_out`=1, `active_out`=0; then `state`=10 with `active_out`=1.
- In IDLE, 3 data words A, B, C, no ctrl → `fifo_pop` for 3 cycles; A, B, C on `data_out` one cycle later; then one IDLE_WORD pad with `valid_out`=1; then `valid_out`=0.
- FIFO continuously non-empty and `ctrl_req` held with word 0x12345678, MAX_BURST=4 → 4 data words, then 0x12345678 (`ctrl_ack` 1 cycle), then data resumes.
- `link_en` dropped after an odd number of RUN words → one pad, then DISABLED; `valid_out`=0 and `active_out`=0; no pop or ack after the drop.
- `reset` asserted mid-TRAIN and mid-RUN → next cycle all outputs are 0 and `state`=00.
- Check across all scenarios → `fifo_pop` & `ctrl_ack` is never 1; total `valid_out` words per session is always even.
